vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Programmable VGA/VESA raster timing generator, the next generation of the fixed 640x480 counter.
- Generates sync, blanking, coordinates and line/frame strobes from a pixel clock-enable.
- Timing is reprogrammed at runtime through a valid/ready config port. Updates take effect only at a frame boundary, so the display never sees a torn frame.
- Sits between the pixel clock domain logic and the VGA pin drivers / framebuffer reader.

Parameters:
- CNT_W, 12, width of the internal horizontal/vertical counters and of every cfg_* field
- COORD_W, 16, width of the signed x/y outputs
- HS_POL, 1, hsync level while asserted (1 = active-high, 0 = active-low)
- VS_POL, 1, vsync level while asserted
- DEF_TIMING, vga_pkg::VGA_640X480, reset/default timing (hsp 96, hbp 48, width 640, hfp 16, vsp 2, vbp 29, height 480, vfp 10)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ce  in  1  pixel clock enable; counters and outputs advance only when ce=1
- cfg_valid  in  1  new timing offered
- cfg_ready  out  1  no update pending; offer accepted when cfg_valid&&cfg_ready
- cfg_timing  in  vga_timing_t  hsp,hbp,width,hfp,vsp,vbp,height,vfp, each CNT_W unsigned
- cfg_err  out  1  one-cycle pulse: offered config rejected
- hsync  out  1  horizontal sync, polarity per HS_POL
- vsync  out  1  vertical sync, polarity per VS_POL
- visible  out  1  active video region
- x  out  COORD_W signed  i - (hsp+hbp)
- y  out  COORD_W signed  j - (vsp+vbp)
- line_start  out  1  one-clk pulse, output for i==0
- frame_start  out  1  one-clk pulse, output for i==0 && j==0

Behaviour:
- Reset (rst=1 at a clk edge):
  - i=j=0; active timing=DEF_TIMING; pending cleared; cfg_ready=1; cfg_err=0.
  - Outputs: hsync=!HS_POL, vsync=!VS_POL, visible=0, x=y=0, line_start=frame_start=0.
  - rst overrides ce and cfg_valid in the same cycle.
- Totals: HT = hsp+hbp+width+hfp, VT = vsp+vbp+height+vfp. Both are computed in CNT_W+2 bits.
- Counting (ce=1): if i<HT-1 then i++; else i=0 and (if j<VT-1 then j++ else j=0).
- Output pipeline (ce=1): outputs register the decode of the pre-increment (i,j), i.e. one ce of latency.
  - hsync asserted iff i<hsp; vsync asserted iff j<vsp.
  - visible iff hsp+hbp <= i < hsp+hbp+width and vsp+vbp <= j < vsp+vbp+height.
  - x and y are sign-extended/truncated to COORD_W.
- ce=0: counters and level outputs hold; line_start and frame_start forced 0, so each pulse is exactly one clk wide.
- Config acceptance (handshake at a cycle with cfg_valid && cfg_ready):
  - Reject and pulse cfg_err on the next cycle, with cfg_ready staying 1, if any of width, height, hsp or vsp is 0, or if HT > 2^CNT_W or VT > 2^CNT_W.
  - Otherwise latch the config into the pending register; cfg_ready=0 from the next cycle.
- Apply: on the ce cycle where i=HT-1 and j=VT-1 with a pending config, the active timing is set to pending and pending is cleared.
  - Counters wrap to 0 as normal, so the first frame in the new timing begins at (0,0).
  - cfg_ready=1 on the following cycle.
- A config accepted on the same cycle as the wrap is not applied at that wrap; it is applied at the next wrap.
- The active timing never changes mid-frame. The decode always uses active timing, never pending.

Decomposition:
- Package vga_pkg:
  - typedef vga_timing_t (packed struct of the 8 CNT_W fields; CNT_W fixed at 12 in the package)
  - localparam VGA_640X480
  - helper functions h_total/v_total
- One sub-module: vga_axis_counter. It is a single-dimension wrap counter with inputs (clk, rst, en, total) and outputs (cnt, wrap). It is instantiated for horizontal and vertical, with vertical en = ce && h.wrap.

Test Plan:
- Reset release, ce=1 constant, defaults:
  - First post-ce outputs: hsync=1, vsync=1, line_start=frame_start=1, x=-144, y=-31, visible=0.
  - hsync high for exactly 96 ce; first visible=1 has x=0, y=0 at output index 144 of line 31.
- Periodicity: line_start every 800 clk; frame_start every 416800 clk; visible count per frame = 307200.
- ce=1 every 2nd clk:
  - Level outputs stable across ce=0 cycles; pulses exactly 1 clk wide.
  - frame_start period 833600 clk.
- Mid-frame config {hsp1,hbp1,width4,hfp1,vsp1,vbp1,height2,vfp1}:
  - cfg_ready=0 next cycle; old timing until the wrap.
  - After the next frame_start: line period 7, frame period 35, visible at x 0..3, y 0..1; cfg_ready=1 after the wrap.
- Config with width=0 (and a separate one with HT=5000): cfg_err single pulse, cfg_ready stays 1, timing unchanged.
- rst mid-frame with a config pending: next cycle outputs inactive, cfg_ready=1. The next frame uses 640x480 defaults (frame period 416800).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing types and helpers for the VGA raster generator.
// Provides vga_timing_t, the 640x480 default and total-length helpers.
package vga_pkg;

    localparam int VGA_CNT_W = 12;

    typedef struct packed {
        logic [VGA_CNT_W-1:0] hsp;
        logic [VGA_CNT_W-1:0] hbp;
        logic [VGA_CNT_W-1:0] width;
        logic [VGA_CNT_W-1:0] hfp;
        logic [VGA_CNT_W-1:0] vsp;
        logic [VGA_CNT_W-1:0] vbp;
        logic [VGA_CNT_W-1:0] height;
        logic [VGA_CNT_W-1:0] vfp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480 = '{
        hsp:    12'd96,
        hbp:    12'd48,
        width:  12'd640,
        hfp:    12'd16,
        vsp:    12'd2,
        vbp:    12'd29,
        height: 12'd480,
        vfp:    12'd10
    };

    // Two extra bits so four maximal fields cannot overflow.
    function automatic logic [VGA_CNT_W+1:0] h_total(input vga_timing_t t);
        return {2'b00, t.hsp} + {2'b00, t.hbp}
             + {2'b00, t.width} + {2'b00, t.hfp};
    endfunction

    function automatic logic [VGA_CNT_W+1:0] v_total(input vga_timing_t t);
        return {2'b00, t.vsp} + {2'b00, t.vbp}
             + {2'b00, t.height} + {2'b00, t.vfp};
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Single-axis wrap counter: counts 0..total-1 while en is high.
// Ports: clk, rst (sync, high), en, total in; cnt, wrap (at last count) out.
module vga_axis_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W+1:0] total,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    // >= rather than == keeps the counter recoverable from any state.
    assign wrap = ({2'b00, cnt} >= (total - (CNT_W+2)'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            if (wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing generator with frame-aligned reconfiguration.
// Ports: clk, rst, ce, cfg_valid/cfg_ready/cfg_timing/cfg_err config port;
// hsync, vsync, visible, x, y, line_start, frame_start registered outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int          CNT_W      = 12,
    parameter int          COORD_W    = 16,
    parameter bit          HS_POL     = 1'b1,
    parameter bit          VS_POL     = 1'b1,
    parameter vga_timing_t DEF_TIMING = VGA_640X480
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  vga_timing_t               cfg_timing,
    output logic                      cfg_err,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      visible,
    output logic signed [COORD_W-1:0] x,
    output logic signed [COORD_W-1:0] y,
    output logic                      line_start,
    output logic                      frame_start
);

    localparam logic [CNT_W+1:0] MAX_T = {2'b01, {CNT_W{1'b0}}};

    vga_timing_t      act;
    vga_timing_t      pend;
    logic             pend_vld;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             frame_end;
    logic [CNT_W+1:0] h_tot;
    logic [CNT_W+1:0] v_tot;
    logic [CNT_W+1:0] cfg_ht;
    logic [CNT_W+1:0] cfg_vt;
    logic             cfg_bad;
    logic [CNT_W+1:0] i_w;
    logic [CNT_W+1:0] j_w;
    logic [CNT_W+1:0] h_start;
    logic [CNT_W+1:0] v_start;
    logic [CNT_W+1:0] h_end;
    logic [CNT_W+1:0] v_end;
    logic [CNT_W+2:0] x_diff;
    logic [CNT_W+2:0] y_diff;
    logic             vis_n;

    assign h_tot = h_total(act);
    assign v_tot = v_total(act);

    vga_axis_counter #(.CNT_W(CNT_W)) u_h (
        .clk   (clk),
        .rst   (rst),
        .en    (ce),
        .total (h_tot),
        .cnt   (h_cnt),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(.CNT_W(CNT_W)) u_v (
        .clk   (clk),
        .rst   (rst),
        .en    (ce && h_wrap),
        .total (v_tot),
        .cnt   (v_cnt),
        .wrap  (v_wrap)
    );

    assign frame_end = ce && h_wrap && v_wrap;
    assign cfg_ready = !pend_vld;

    assign cfg_ht  = h_total(cfg_timing);
    assign cfg_vt  = v_total(cfg_timing);
    assign cfg_bad = (cfg_timing.width == '0) || (cfg_timing.height == '0)
                  || (cfg_timing.hsp == '0) || (cfg_timing.vsp == '0)
                  || (cfg_ht > MAX_T) || (cfg_vt > MAX_T);

    // Apply happens before accept in program order: a config taken on the
    // wrap cycle itself lands in pending and waits for the next wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            act      <= DEF_TIMING;
            pend     <= '0;
            pend_vld <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (frame_end && pend_vld) begin
                act      <= pend;
                pend_vld <= 1'b0;
            end
            if (cfg_valid && cfg_ready) begin
                if (cfg_bad) begin
                    cfg_err <= 1'b1;
                end else begin
                    pend     <= cfg_timing;
                    pend_vld <= 1'b1;
                end
            end
        end
    end

    assign i_w     = {2'b00, h_cnt};
    assign j_w     = {2'b00, v_cnt};
    assign h_start = {2'b00, act.hsp} + {2'b00, act.hbp};
    assign v_start = {2'b00, act.vsp} + {2'b00, act.vbp};
    assign h_end   = h_start + {2'b00, act.width};
    assign v_end   = v_start + {2'b00, act.height};
    assign x_diff  = {1'b0, i_w} - {1'b0, h_start};
    assign y_diff  = {1'b0, j_w} - {1'b0, v_start};
    assign vis_n   = (i_w >= h_start) && (i_w < h_end)
                  && (j_w >= v_start) && (j_w < v_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= !HS_POL;
            vsync       <= !VS_POL;
            visible     <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            hsync       <= (i_w < {2'b00, act.hsp}) ? HS_POL : !HS_POL;
            vsync       <= (j_w < {2'b00, act.vsp}) ? VS_POL : !VS_POL;
            visible     <= vis_n;
            x           <= COORD_W'($signed(x_diff));
            y           <= COORD_W'($signed(y_diff));
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a 640x480 instance for line-level
// checks and a small-timing instance driven against a scoreboard model.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam bit S_HSP = 1'b0;
    localparam bit S_VSP = 1'b1;
    localparam vga_timing_t DEF_S = '{
        hsp: 12'd2, hbp: 12'd3, width: 12'd8, hfp: 12'd2,
        vsp: 12'd1, vbp: 12'd2, height: 12'd4, vfp: 12'd1
    };

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        vis;
        logic [15:0] x;
        logic [15:0] y;
        logic        ls;
        logic        fs;
        logic        rdy;
        logic        err;
    } obs_t;

    typedef struct {
        string       nm;
        vga_timing_t t;
        bit          bad;
        int          period;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-timing instance
    logic               d_rst = 1'b1;
    logic               d_ce = 1'b0;
    logic               d_cfg_valid = 1'b0;
    vga_timing_t        d_cfg_timing = '0;
    logic               d_cfg_ready, d_cfg_err, d_hsync, d_vsync, d_visible;
    logic signed [15:0] d_x, d_y;
    logic               d_line_start, d_frame_start;

    vga_timing_gen u_def (
        .clk(clk), .rst(d_rst), .ce(d_ce),
        .cfg_valid(d_cfg_valid), .cfg_ready(d_cfg_ready),
        .cfg_timing(d_cfg_timing), .cfg_err(d_cfg_err),
        .hsync(d_hsync), .vsync(d_vsync), .visible(d_visible),
        .x(d_x), .y(d_y),
        .line_start(d_line_start), .frame_start(d_frame_start)
    );

    // small-timing instance
    logic               rst = 1'b1;
    logic               ce = 1'b0;
    logic               cfg_valid = 1'b0;
    vga_timing_t        cfg_timing = '0;
    logic               cfg_ready, cfg_err, hsync, vsync, visible;
    logic signed [15:0] x, y;
    logic               line_start, frame_start;

    vga_timing_gen #(
        .HS_POL(S_HSP), .VS_POL(S_VSP), .DEF_TIMING(DEF_S)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_timing(cfg_timing), .cfg_err(cfg_err),
        .hsync(hsync), .vsync(vsync), .visible(visible),
        .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fs_cnt = 0;
    int fs_last = 0;
    int fs_prev = 0;

    // reference model state
    int          m_i, m_j;
    vga_timing_t m_act, m_pend;
    bit          m_pv;
    obs_t        m_out;
    obs_t        sb[$];

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic vga_timing_t mk(int a, int b, int c, int d,
                                       int e, int f, int g, int h);
        vga_timing_t t;
        t.hsp = 12'(a); t.hbp = 12'(b); t.width = 12'(c); t.hfp = 12'(d);
        t.vsp = 12'(e); t.vbp = 12'(f); t.height = 12'(g); t.vfp = 12'(h);
        return t;
    endfunction

    function automatic int ht(vga_timing_t t);
        return int'(t.hsp) + int'(t.hbp) + int'(t.width) + int'(t.hfp);
    endfunction

    function automatic int vt(vga_timing_t t);
        return int'(t.vsp) + int'(t.vbp) + int'(t.height) + int'(t.vfp);
    endfunction

    function automatic bit is_bad(vga_timing_t t);
        return t.width == 0 || t.height == 0 || t.hsp == 0 || t.vsp == 0
            || ht(t) > 4096 || vt(t) > 4096;
    endfunction

    function automatic void model(bit r, bit c, bit v, vga_timing_t t);
        int  hb, vb, h_t, v_t;
        bit  acc, wrap;
        if (r) begin
            m_i = 0; m_j = 0; m_act = DEF_S; m_pv = 1'b0;
            m_out = '{hs: !S_HSP, vs: !S_VSP, vis: 1'b0, x: 16'd0,
                      y: 16'd0, ls: 1'b0, fs: 1'b0, rdy: 1'b1, err: 1'b0};
        end else begin
            acc = v && !m_pv;
            hb  = int'(m_act.hsp) + int'(m_act.hbp);
            vb  = int'(m_act.vsp) + int'(m_act.vbp);
            h_t = ht(m_act);
            v_t = vt(m_act);
            if (c) begin
                m_out.hs  = (m_i < int'(m_act.hsp)) ? S_HSP : !S_HSP;
                m_out.vs  = (m_j < int'(m_act.vsp)) ? S_VSP : !S_VSP;
                m_out.vis = m_i >= hb && m_i < hb + int'(m_act.width)
                         && m_j >= vb && m_j < vb + int'(m_act.height);
                m_out.x   = 16'(m_i - hb);
                m_out.y   = 16'(m_j - vb);
                m_out.ls  = (m_i == 0);
                m_out.fs  = (m_i == 0 && m_j == 0);
            end else begin
                m_out.ls = 1'b0;
                m_out.fs = 1'b0;
            end
            wrap = c && m_i == h_t - 1 && m_j == v_t - 1;
            if (c) begin
                if (m_i == h_t - 1) begin
                    m_i = 0;
                    m_j = (m_j == v_t - 1) ? 0 : m_j + 1;
                end else begin
                    m_i++;
                end
            end
            if (wrap && m_pv) begin
                m_act = m_pend;
                m_pv  = 1'b0;
            end
            m_out.err = 1'b0;
            if (acc) begin
                if (is_bad(t)) begin
                    m_out.err = 1'b1;
                end else begin
                    m_pend = t;
                    m_pv   = 1'b1;
                end
            end
            m_out.rdy = !m_pv;
        end
        sb.push_back(m_out);
    endfunction

    task automatic step(input bit r, input bit c, input bit v,
                        input vga_timing_t t);
        obs_t e, a;
        rst = r; ce = c; cfg_valid = v; cfg_timing = t;
        model(r, c, v, t);
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        a = '{hs: hsync, vs: vsync, vis: visible, x: x, y: y,
              ls: line_start, fs: frame_start, rdy: cfg_ready, err: cfg_err};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL out@%0d: got %h expected %h", cyc, a, e);
        end
        if (frame_start) begin
            fs_prev = fs_last;
            fs_last = cyc;
            fs_cnt++;
        end
    endtask

    task automatic run_to_fs(input string nm, input int target,
                             input int bound);
        int n;
        n = 0;
        while (fs_cnt < target && n < bound) begin
            step(1'b0, 1'b1, 1'b0, '0);
            n++;
        end
        chk({nm, "_reached"}, 64'(fs_cnt >= target), 64'd1);
    endtask

    obs_t dexp;
    vec_t tbl[7];

    initial begin
        int hs_end, first_vis, vis_n, fs_n, ls_last, p0, n;

        // ---- 640x480 default instance ----
        repeat (2) @(posedge clk);
        #1;
        dexp = '{hs: 1'b0, vs: 1'b0, vis: 1'b0, x: 16'd0, y: 16'd0,
                 ls: 1'b0, fs: 1'b0, rdy: 1'b1, err: 1'b0};
        chk("def_reset", {d_hsync, d_vsync, d_visible, d_x, d_y,
            d_line_start, d_frame_start, d_cfg_ready, d_cfg_err}, dexp);
        d_rst = 1'b0;
        d_ce  = 1'b1;
        @(posedge clk);
        #1;
        dexp = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, x: 16'hFF70, y: 16'hFFE1,
                 ls: 1'b1, fs: 1'b1, rdy: 1'b1, err: 1'b0};
        chk("def_first", {d_hsync, d_vsync, d_visible, d_x, d_y,
            d_line_start, d_frame_start, d_cfg_ready, d_cfg_err}, dexp);
        hs_end = -1; first_vis = -1; vis_n = 0; fs_n = 1; ls_last = 0;
        for (int k = 1; k <= 25700; k++) begin
            @(posedge clk);
            #1;
            if (hs_end < 0 && !d_hsync) hs_end = k;
            if (d_line_start) begin
                chk("def_line_period", 64'(k - ls_last), 64'd800);
                ls_last = k;
            end
            if (d_frame_start) fs_n++;
            if (d_visible) begin
                vis_n++;
                if (first_vis < 0) begin
                    first_vis = k;
                    chk("def_first_vis_xy", {d_x, d_y}, 64'd0);
                end
            end
        end
        chk("def_hsync_width", 64'(hs_end), 64'd96);
        chk("def_first_vis_at", 64'(first_vis), 64'(31 * 800 + 144));
        chk("def_vis_line31", 64'(vis_n), 64'd640);
        chk("def_fs_count", 64'(fs_n), 64'd1);
        d_ce = 1'b0;

        // ---- small instance, scoreboard-checked every cycle ----
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, '0);
        repeat (300) step(1'b0, 1'b1, 1'b0, '0);
        chk("fs_period_ce1", 64'(fs_last - fs_prev), 64'd120);
        for (int k = 0; k < 480; k++) step(1'b0, (k % 2) == 0, 1'b0, '0);
        chk("fs_period_ce2", 64'(fs_last - fs_prev), 64'd240);

        tbl[0] = '{"small7x5", mk(1, 1, 4, 1, 1, 1, 2, 1), 1'b0, 35};
        tbl[1] = '{"width0", mk(1, 1, 0, 1, 1, 1, 2, 1), 1'b1, 35};
        tbl[2] = '{"ht5002", mk(4000, 1000, 1, 1, 1, 1, 2, 1), 1'b1, 35};
        tbl[3] = '{"vsp0", mk(1, 1, 4, 1, 0, 1, 2, 1), 1'b1, 35};
        tbl[4] = '{"vt4097", mk(1, 1, 4, 1, 1, 4095, 1, 0), 1'b1, 35};
        tbl[5] = '{"ht4096", mk(1, 1, 4093, 1, 1, 0, 1, 0), 1'b0, 8192};
        tbl[6] = '{"back_def", DEF_S, 1'b0, 120};

        run_to_fs("align", fs_cnt + 1, 300);
        for (int e = 0; e < 7; e++) begin
            p0 = fs_cnt;
            step(1'b0, 1'b1, 1'b1, tbl[e].t);
            chk({tbl[e].nm, "_err"}, 64'(cfg_err), 64'(tbl[e].bad));
            chk({tbl[e].nm, "_ready"}, 64'(cfg_ready), 64'(tbl[e].bad));
            run_to_fs(tbl[e].nm, p0 + 2, 20000);
            chk({tbl[e].nm, "_period"}, 64'(fs_last - fs_prev),
                64'(tbl[e].period));
        end

        // config accepted on the wrap cycle waits for the following wrap
        n = 0;
        while (!(m_i == 14 && m_j == 7) && n < 200) begin
            step(1'b0, 1'b1, 1'b0, '0);
            n++;
        end
        chk("wrap_seek", 64'(n < 200), 64'd1);
        p0 = fs_cnt;
        step(1'b0, 1'b1, 1'b1, tbl[0].t);
        run_to_fs("wrap_old", p0 + 2, 400);
        chk("wrap_old_period", 64'(fs_last - fs_prev), 64'd120);
        run_to_fs("wrap_new", p0 + 3, 400);
        chk("wrap_new_period", 64'(fs_last - fs_prev), 64'd35);
        chk("wrap_ready", 64'(cfg_ready), 64'd1);

        // reset mid-frame with a pending config
        step(1'b0, 1'b1, 1'b1, tbl[5].t);
        step(1'b0, 1'b1, 1'b1, tbl[1].t);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, tbl[0].t);
        chk("rst_ready", 64'(cfg_ready), 64'd1);
        chk("rst_hsync", 64'(hsync), 64'(!S_HSP));
        p0 = fs_cnt;
        run_to_fs("post_rst", p0 + 2, 400);
        chk("post_rst_period", 64'(fs_last - fs_prev), 64'd120);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
